// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, sizing constants
// and the request address check.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int DMEM_LAT_MAX = 4;
  localparam int WORD_BYTES   = 4;

  // A request is bad if it is not word aligned or lies beyond the RAM.
  function automatic logic addr_err(input logic [31:0] addr, input int addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_ram_1rw.sv
// Single-port 32-bit synchronous RAM with per-byte write enables and a
// registered read port; contents are not reset.
module dmem_ram_1rw
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_W];

  // The read register only updates when enabled, so it holds its word between accesses.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the pipeline memory stage: one outstanding request,
// byte-enabled stores, fixed-latency responses with an error flag.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int CNT_W = $clog2(DMEM_LAT_MAX + 1);

  dmem_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  logic             load_q;
  logic             accept;
  logic             req_err;
  logic [3:0]       ram_be;
  logic [31:0]      ram_rdata;

  assign accept  = req_valid && req_ready;
  assign req_err = addr_err(req_addr, ADDR_W);
  assign ram_be  = (req_we && !req_err) ? req_be : 4'b0000;

  dmem_ram_1rw #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (accept),
    .be    (ram_be),
    .addr  (req_addr[ADDR_W+1:2]),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );

  // The RAM read register holds the loaded word until the next accept, so only
  // the selection flags need to be captured here.
  assign rsp_rdata = (rsp_valid && load_q) ? ram_rdata : 32'd0;
  assign rsp_err   = rsp_valid && err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      err_q     <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt       <= CNT_W'(READ_LAT - 1);
            err_q     <= req_err;
            load_q    <= !req_we && !req_err;
            req_ready <= 1'b0;
            if (READ_LAT > 1) begin
              state <= WAIT;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (READ_LAT 2, 1, 4)
// driven with directed and random requests against a word-array memory model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int tests = 0;
  int fails = 0;
  bit [31:0] mem [3][256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .ADDR_W   (8),
      .READ_LAT ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  function automatic int lat_of(input int idx);
    return (idx == 0) ? 2 : ((idx == 1) ? 1 : 4);
  endfunction

  // One complete transaction, checked against the memory model. While busy the
  // bench keeps req_valid high with a junk store that must never be accepted.
  task automatic do_req(input int idx, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int hold, input bit early, input string name);
    int          waited;
    int          lat;
    int          w;
    bit          seen;
    logic [31:0] word;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] got_rdata;
    logic        got_err;

    exp_err   = (addr % 4 != 0) || (addr >= 32'd1024);
    exp_rdata = 32'd0;
    if (!exp_err) begin
      w    = int'(addr / 4);
      word = mem[idx][w];
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
        mem[idx][w] = word;
      end else begin
        exp_rdata = word;
      end
    end

    @(negedge clk);
    req_valid[idx] = 1'b1;
    req_we[idx]    = we;
    req_addr[idx]  = addr;
    req_wdata[idx] = wdata;
    req_be[idx]    = be;
    rsp_ready[idx] = 1'b0;
    waited = 0;
    while (req_ready[idx] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (req_ready[idx] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s accept_timeout: req_ready=%b required 1", name, req_ready[idx]);
      req_valid[idx] = 1'b0;
      return;
    end

    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      req_we[idx]    = 1'b1;
      req_addr[idx]  = 32'($urandom_range(0, 15) * 4);
      req_wdata[idx] = $urandom;
      req_be[idx]    = 4'hF;
      if (early) rsp_ready[idx] = 1'b1;
      if (rsp_valid[idx] === 1'b1) begin
        seen = 1'b1;
      end else begin
        tests++;
        if (req_ready[idx] !== 1'b0) begin
          fails++;
          $display("[TB] FAIL %s busy_ready: req_ready=%b required 0", name, req_ready[idx]);
        end
      end
    end
    tests++;
    if (!seen || lat != lat_of(idx)) begin
      fails++;
      $display("[TB] FAIL %s latency: got %0d cycles (seen=%0b) required %0d",
               name, lat, seen, lat_of(idx));
    end
    if (!seen) begin
      req_valid[idx] = 1'b0;
      rsp_ready[idx] = 1'b0;
      return;
    end

    got_rdata = rsp_rdata[idx];
    got_err   = rsp_err[idx];
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        tests++;
        if (rsp_valid[idx] !== 1'b1 || rsp_rdata[idx] !== got_rdata ||
            rsp_err[idx] !== got_err || req_ready[idx] !== 1'b0) begin
          fails++;
          $display("[TB] FAIL %s hold: valid=%b rdata=%h err=%b ready=%b required 1/%h/%b/0",
                   name, rsp_valid[idx], rsp_rdata[idx], rsp_err[idx], req_ready[idx],
                   got_rdata, got_err);
        end
      end
    end
    rsp_ready[idx] = 1'b1;
    @(negedge clk);
    rsp_ready[idx] = 1'b0;
    req_valid[idx] = 1'b0;
    tests++;
    if (rsp_valid[idx] !== 1'b0 || req_ready[idx] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s handshake: valid=%b ready=%b required 0/1",
               name, rsp_valid[idx], req_ready[idx]);
    end
    tests++;
    if (got_rdata !== exp_rdata || got_err !== exp_err) begin
      fails++;
      $display("[TB] FAIL %s response: rdata=%h err=%b required %h/%b",
               name, got_rdata, got_err, exp_rdata, exp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
      req_be[i]    = 4'h0;
      rsp_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (req_ready[i] !== 1'b0 || rsp_valid[i] !== 1'b0 ||
          rsp_rdata[i] !== 32'd0 || rsp_err[i] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_state[%0d]: ready=%b valid=%b rdata=%h err=%b required 0/0/0/0",
                 i, req_ready[i], rsp_valid[i], rsp_rdata[i], rsp_err[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (req_ready[i] !== 1'b1 || rsp_valid[i] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_release[%0d]: ready=%b valid=%b required 1/0",
                 i, req_ready[i], rsp_valid[i]);
      end
    end
  endtask

  task automatic test_store_load();
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, "store_10");
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, "load_10");
  endtask

  task automatic test_byte_enable();
    do_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF, 0, 1'b0, "store_20");
    do_req(0, 1'b1, 32'h20, 32'h11223344, 4'b0101, 0, 1'b0, "store_20_be5");
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, "load_20_merged");
    do_req(0, 1'b1, 32'h20, 32'h55555555, 4'h0, 0, 1'b0, "store_be0");
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, "load_after_be0");
  endtask

  task automatic test_errors();
    do_req(0, 1'b0, 32'h22, 32'h0, 4'h0, 0, 1'b0, "load_misaligned");
    do_req(0, 1'b0, 32'h400, 32'h0, 4'h0, 0, 1'b0, "load_out_of_range");
    do_req(0, 1'b1, 32'h21, 32'h99999999, 4'hF, 0, 1'b0, "store_misaligned");
    do_req(0, 1'b1, 32'h420, 32'h77777777, 4'hF, 0, 1'b0, "store_out_of_range");
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, "load_20_unchanged");
  endtask

  task automatic test_backpressure();
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 10, 1'b0, "backpressure_load");
    do_req(0, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, 10, 1'b0, "backpressure_store");
  endtask

  task automatic test_back_to_back();
    for (int idx = 1; idx < 3; idx++) begin
      for (int w = 0; w < 16; w++)
        do_req(idx, 1'b1, 32'(w * 4), $urandom, 4'hF, 0, 1'b0, "b2b_fill");
      for (int w = 0; w < 4; w++)
        do_req(idx, 1'b0, 32'(w * 4), 32'h0, 4'h0, 0, 1'b0, "b2b_load");
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int w = 0; w < 16; w++)
      do_req(0, 1'b1, 32'(w * 4), $urandom, 4'hF, 0, 1'b0, "rand_fill");
    for (int n = 0; n < 120; n++) begin
      int  idx;
      int  pick;
      idx  = n % 3;
      pick = $urandom_range(0, 19);
      if (pick == 0)      addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      else if (pick == 1) addr = 32'd1024 + 32'($urandom_range(0, 255) * 4);
      else                addr = 32'($urandom_range(0, 15) * 4);
      do_req(idx, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), ($urandom_range(0, 4) == 0), "random");
    end
  endtask

  task automatic test_reset_mid();
    int          waited;
    logic [31:0] val;
    val = $urandom;
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 32'h14;
    req_wdata[2] = val;
    req_be[2]    = 4'hF;
    rsp_ready[2] = 1'b0;
    waited = 0;
    while (req_ready[2] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (req_ready[2] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rst_mid_accept: req_ready=%b required 1", req_ready[2]);
    end
    mem[2][5] = val;
    @(negedge clk);
    rst = 1'b1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    tests++;
    if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rst_mid_store: valid=%b ready=%b required 0/0", rsp_valid[2], req_ready[2]);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready[2] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rst_mid_release1: req_ready=%b required 1", req_ready[2]);
    end

    req_valid[2] = 1'b1;
    req_we[2]    = 1'b0;
    req_addr[2]  = 32'h14;
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid[2] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL rst_mid_no_rsp: cycle %0d rsp_valid=%b required 0", c, rsp_valid[2]);
      end
    end
    tests++;
    if (req_ready[2] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rst_mid_release2: req_ready=%b required 1", req_ready[2]);
    end
    do_req(2, 1'b0, 32'h14, 32'h0, 4'h0, 0, 1'b0, "rst_mid_readback");
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
